// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction and operands, detects load-use hazards.
// IDEX_FORWARD_EN defined: EX/MEM and MEM/WB forwarding on the outputs. Undefined: raw operands with a full interlock.
module id_ex_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        hold,
    input  logic        exmem_wr_en,
    input  logic [4:0]  exmem_wr_addr,
    input  logic [31:0] exmem_wr_data,
    input  logic        memwb_wr_en,
    input  logic [4:0]  memwb_wr_addr,
    input  logic [31:0] memwb_wr_data,
    output logic [31:0] instruction,
    output logic [31:0] regA,
    output logic [31:0] regB,
    output logic        ex_valid,
    output logic [4:0]  ex_dest,
    output logic        ex_is_load,
    output logic        stall_req
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [31:0] instr_q, rs_q, rt_q;
    logic        valid_q, load_q;
    logic [4:0]  dest_q;

    logic [5:0] id_op, id_funct;
    logic [4:0] id_rs, id_rt, id_rd;
    assign id_op    = id_instr[31:26];
    assign id_rs    = id_instr[25:21];
    assign id_rt    = id_instr[20:16];
    assign id_rd    = id_instr[15:11];
    assign id_funct = id_instr[5:0];

    logic [4:0] id_dest;
    logic       id_load, id_rs_used, id_rt_used;

    always_comb begin
        id_dest    = 5'd0;
        id_load    = 1'b0;
        id_rs_used = 1'b1;
        id_rt_used = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                id_dest    = id_rd;
                id_rt_used = 1'b1;
                // Shift-immediates take their operand from rt and the amount from shamt.
                if (id_funct == 6'b000000 || id_funct == 6'b000010 || id_funct == 6'b000011)
                    id_rs_used = 1'b0;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI:   id_dest = id_rt;
            OP_LW: begin
                id_dest = id_rt;
                id_load = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE:      id_rt_used = 1'b1;
            default:                    id_dest = 5'd0;
        endcase
        if (!id_valid) begin
            id_dest = 5'd0;
            id_load = 1'b0;
        end
    end

    logic ex_hit, hazard;
    assign ex_hit = valid_q && dest_q != 5'd0 &&
                    ((id_rs_used && id_rs == dest_q) || (id_rt_used && id_rt == dest_q));

`ifdef IDEX_FORWARD_EN
    assign hazard = ex_hit && load_q;

    logic [4:0] ex_rs, ex_rt;
    assign ex_rs = instr_q[25:21];
    assign ex_rt = instr_q[20:16];

    // EX/MEM is checked first so the youngest producer wins.
    always_comb begin
        regA = rs_q;
        regB = rt_q;
        if (exmem_wr_en && exmem_wr_addr != 5'd0 && exmem_wr_addr == ex_rs)
            regA = exmem_wr_data;
        else if (memwb_wr_en && memwb_wr_addr != 5'd0 && memwb_wr_addr == ex_rs)
            regA = memwb_wr_data;
        if (exmem_wr_en && exmem_wr_addr != 5'd0 && exmem_wr_addr == ex_rt)
            regB = exmem_wr_data;
        else if (memwb_wr_en && memwb_wr_addr != 5'd0 && memwb_wr_addr == ex_rt)
            regB = memwb_wr_data;
    end

    logic unused_bits;
    assign unused_bits = ^{id_instr[10:6], instr_q[31:26], instr_q[15:0]};
`else
    logic mem_hit;
    assign mem_hit = exmem_wr_en && exmem_wr_addr != 5'd0 &&
                     ((id_rs_used && id_rs == exmem_wr_addr) || (id_rt_used && id_rt == exmem_wr_addr));
    assign hazard  = ex_hit || mem_hit;

    assign regA = rs_q;
    assign regB = rt_q;

    logic unused_bits;
    assign unused_bits = ^{id_instr[10:6], exmem_wr_data, memwb_wr_en, memwb_wr_addr,
                           memwb_wr_data, load_q};
`endif

    assign stall_req = hazard && id_valid && !flush && !hold && !rst;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && stall_req)) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            dest_q  <= 5'd0;
            load_q  <= 1'b0;
            if (rst) begin
                rs_q <= 32'd0;
                rt_q <= 32'd0;
            end
        end else if (!hold) begin
            instr_q <= id_instr;
            rs_q    <= id_rs_data;
            rt_q    <= id_rt_data;
            valid_q <= id_valid;
            dest_q  <= id_dest;
            load_q  <= id_load;
        end
    end

    assign instruction = instr_q;
    assign ex_valid    = valid_q;
    assign ex_dest     = dest_q;
    assign ex_is_load  = load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a slot-level model checked every cycle plus literal checkpoints.
module tb_id_ex_stage;

`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, id_valid, flush, hold, exmem_wr_en, memwb_wr_en;
    logic [31:0] id_instr, id_rs_data, id_rt_data, exmem_wr_data, memwb_wr_data;
    logic [4:0]  exmem_wr_addr, memwb_wr_addr;
    logic [31:0] instruction, regA, regB;
    logic        ex_valid, ex_is_load, stall_req;
    logic [4:0]  ex_dest;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_valid(id_valid), .flush(flush), .hold(hold),
        .exmem_wr_en(exmem_wr_en), .exmem_wr_addr(exmem_wr_addr), .exmem_wr_data(exmem_wr_data),
        .memwb_wr_en(memwb_wr_en), .memwb_wr_addr(memwb_wr_addr), .memwb_wr_data(memwb_wr_data),
        .instruction(instruction), .regA(regA), .regB(regB), .ex_valid(ex_valid),
        .ex_dest(ex_dest), .ex_is_load(ex_is_load), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what sits in EX is just a slot; destination and load-ness are derived from it.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        bit          valid;
    } slot_t;

    slot_t ex_slot;

    function automatic logic [4:0] dest_of(input logic [31:0] ins, input bit v);
        logic [5:0] op = ins[31:26];
        if (!v) return 5'd0;
        if (op == 6'd0) return ins[15:11];
        if (op inside {6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110,
                       6'b001010, 6'b001011, 6'b100011}) return ins[20:16];
        return 5'd0;
    endfunction

    function automatic bit is_lw(input logic [31:0] ins, input bit v);
        return v && ins[31:26] == 6'b100011;
    endfunction

    function automatic bit reads_rs(input logic [31:0] ins);
        return !(ins[31:26] == 6'd0 && ins[5:0] inside {6'b000000, 6'b000010, 6'b000011});
    endfunction

    function automatic bit reads_rt(input logic [31:0] ins);
        return ins[31:26] inside {6'b000000, 6'b101011, 6'b000100, 6'b000101};
    endfunction

    function automatic bit model_stall();
        logic [4:0] srcs [2];
        bit         used [2];
        logic [4:0] d;
        if (rst || flush || hold || !id_valid) return 1'b0;
        srcs[0] = id_instr[25:21]; used[0] = reads_rs(id_instr);
        srcs[1] = id_instr[20:16]; used[1] = reads_rt(id_instr);
        d = dest_of(ex_slot.instr, ex_slot.valid);
        for (int i = 0; i < 2; i++) begin
            if (!used[i]) continue;
            if (d != 5'd0 && srcs[i] == d && (!FWD || is_lw(ex_slot.instr, ex_slot.valid)))
                return 1'b1;
            if (!FWD && exmem_wr_en && exmem_wr_addr != 5'd0 && srcs[i] == exmem_wr_addr)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] field, input logic [31:0] raw);
        if (!FWD || field == 5'd0) return raw;
        if (exmem_wr_en && exmem_wr_addr == field) return exmem_wr_data;
        if (memwb_wr_en && memwb_wr_addr == field) return memwb_wr_data;
        return raw;
    endfunction

    always @(posedge clk) begin
        if (rst)
            ex_slot <= '{instr: 32'd0, a: 32'd0, b: 32'd0, valid: 1'b0};
        else if (flush)
            ex_slot <= '{instr: 32'd0, a: ex_slot.a, b: ex_slot.b, valid: 1'b0};
        else if (hold)
            ex_slot <= ex_slot;
        else if (model_stall())
            ex_slot <= '{instr: 32'd0, a: ex_slot.a, b: ex_slot.b, valid: 1'b0};
        else
            ex_slot <= '{instr: id_instr, a: id_rs_data, b: id_rt_data, valid: id_valid};
    end

    // Bubbles carry stale operand data, which only matters as a don't-care for nop; compare anyway.
    always @(negedge clk) begin
        if (armed) begin
            check("m_instruction", instruction, ex_slot.instr);
            check("m_regA", regA, model_operand(ex_slot.instr[25:21], ex_slot.a));
            check("m_regB", regB, model_operand(ex_slot.instr[20:16], ex_slot.b));
            check("m_ex_valid", {31'd0, ex_valid}, {31'd0, ex_slot.valid});
            check("m_ex_dest", {27'd0, ex_dest}, {27'd0, dest_of(ex_slot.instr, ex_slot.valid)});
            check("m_ex_is_load", {31'd0, ex_is_load}, {31'd0, is_lw(ex_slot.instr, ex_slot.valid)});
            check("m_stall_req", {31'd0, stall_req}, {31'd0, model_stall()});
        end
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_id(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic v);
        id_instr = ins; id_rs_data = a; id_rt_data = b; id_valid = v;
    endtask

    localparam logic [31:0] ADD_0_0_1 = 32'h0001_0020;   // add $0,$0,$1
    localparam logic [31:0] ADD_5_3_4 = 32'h0064_2820;   // add $5,$3,$4
    localparam logic [31:0] ADD_6_5_1 = 32'h00A1_3020;   // add $6,$5,$1
    localparam logic [31:0] LW_5      = 32'h8C05_0000;   // lw $5,0($0)

    int stalls;

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        set_id(32'hDEAD_BEEF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        exmem_wr_en = 1'b1; exmem_wr_addr = 5'd3; exmem_wr_data = 32'hFFFF_0000;
        memwb_wr_en = 1'b1; memwb_wr_addr = 5'd4; memwb_wr_data = 32'h0000_FFFF;

        edge_step();
        armed = 1'b1;
        edge_step();
        mid();
        check("reset_instruction", instruction, 32'd0);
        check("reset_regA", regA, 32'd0);
        check("reset_regB", regB, 32'd0);
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);

        // Plain capture.
        edge_step();
        rst = 1'b0; exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
        set_id(ADD_0_0_1, 32'd7, 32'd9, 1'b1);
        edge_step();
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        mid();
        check("cap_instruction", instruction, ADD_0_0_1);
        check("cap_regA", regA, 32'd7);
        check("cap_regB", regB, 32'd9);
        check("cap_ex_dest", {27'd0, ex_dest}, 32'd0);

        // EX/MEM beats MEM/WB; hold freezes the captured add.
        edge_step();
        set_id(ADD_5_3_4, 32'd1, 32'd2, 1'b1);
        edge_step();
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        hold = 1'b1;
        exmem_wr_en = 1'b1; exmem_wr_addr = 5'd3; exmem_wr_data = 32'h11;
        memwb_wr_en = 1'b1; memwb_wr_addr = 5'd3; memwb_wr_data = 32'h22;
        mid();
        check("prio_regA_both", regA, FWD ? 32'h11 : 32'd1);
        edge_step();
        memwb_wr_addr = 5'd4; memwb_wr_data = 32'h33;
        mid();
        check("prio_regA", regA, FWD ? 32'h11 : 32'd1);
        check("prio_regB", regB, FWD ? 32'h33 : 32'd2);
        check("hold_instruction", instruction, ADD_5_3_4);

        // $0 is never forwarded.
        edge_step();
        hold = 1'b0; exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
        set_id(ADD_0_0_1, 32'h55, 32'h66, 1'b1);
        edge_step();
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        exmem_wr_en = 1'b1; exmem_wr_addr = 5'd0; exmem_wr_data = 32'hDEAD;
        mid();
        check("zero_regA", regA, 32'h55);

        // Load-use: one bubble, then the dependent add captures.
        edge_step();
        exmem_wr_en = 1'b0;
        set_id(LW_5, 32'd0, 32'd0, 1'b1);
        edge_step();
        set_id(ADD_6_5_1, 32'h5, 32'h1, 1'b1);
        mid();
        check("lu_stall", {31'd0, stall_req}, 32'd1);
        check("lu_is_load", {31'd0, ex_is_load}, 32'd1);
        check("lu_dest", {27'd0, ex_dest}, 32'd5);
        edge_step();
        mid();
        check("lu_bubble_instr", instruction, 32'd0);
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_stall_drop", {31'd0, stall_req}, 32'd0);
        edge_step();
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        mid();
        check("lu_after_instr", instruction, ADD_6_5_1);
        check("lu_after_dest", {27'd0, ex_dest}, 32'd6);

        // Flush outranks hold and the pending load-use.
        edge_step();
        set_id(LW_5, 32'd0, 32'd0, 1'b1);
        edge_step();
        set_id(ADD_6_5_1, 32'h5, 32'h1, 1'b1);
        flush = 1'b1; hold = 1'b1;
        mid();
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        edge_step();
        flush = 1'b0; hold = 1'b0;
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        mid();
        check("flush_instr", instruction, 32'd0);
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_is_load", {31'd0, ex_is_load}, 32'd0);

        // Reset during a pending load-use.
        edge_step();
        set_id(LW_5, 32'd0, 32'd0, 1'b1);
        edge_step();
        set_id(ADD_6_5_1, 32'h5, 32'h1, 1'b1);
        rst = 1'b1;
        mid();
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        edge_step();
        rst = 1'b0;
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        mid();
        check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_mid_dest", {27'd0, ex_dest}, 32'd0);

        // Back-to-back dependent adds: the interlock build bubbles twice.
        edge_step();
        set_id(ADD_5_3_4, 32'd1, 32'd2, 1'b1);
        edge_step();
        set_id(ADD_6_5_1, 32'h5, 32'h1, 1'b1);
        stalls = 0;
        mid();
        stalls += int'(stall_req);
        edge_step();
        exmem_wr_en = 1'b1; exmem_wr_addr = 5'd5; exmem_wr_data = 32'h77;
        mid();
        stalls += int'(stall_req);
        edge_step();
        exmem_wr_en = 1'b0;
        memwb_wr_en = 1'b1; memwb_wr_addr = 5'd5; memwb_wr_data = 32'h77;
        mid();
        stalls += int'(stall_req);
        edge_step();
        memwb_wr_en = 1'b0;
        set_id(32'd0, 32'd0, 32'd0, 1'b0);
        mid();
        check("b2b_stall_cycles", stalls, FWD ? 32'd0 : 32'd2);
        check("b2b_instr", instruction, ADD_6_5_1);

        edge_step();
        armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the pipelined MIPS CPU, directly upstream of the alu.
- Captures the decoded instruction and both register-file operands each cycle.
- Applies EX/MEM and MEM/WB operand forwarding on its outputs.
- Detects load-use hazards and inserts bubbles.
- Outputs `instruction`, `regA` (rs value) and `regB` (rt value) wire straight to the alu ports of the same names.

Parameters:
- NOP_WORD, 32'h00000000, bubble/reset instruction word (sll $0,$0,0).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- id_instr  input  32  instruction in ID.
- id_rs_data  input  32  register-file read of rs.
- id_rt_data  input  32  register-file read of rt.
- id_valid  input  1  ID holds a real instruction.
- flush  input  1  squash ID (taken branch).
- hold  input  1  downstream stall; freeze ID/EX.
- exmem_wr_en  input  1  EX/MEM writes a register.
- exmem_wr_addr  input  5  EX/MEM destination.
- exmem_wr_data  input  32  EX/MEM alu result.
- memwb_wr_en  input  1  MEM/WB writes a register.
- memwb_wr_addr  input  5  MEM/WB destination.
- memwb_wr_data  input  32  MEM/WB writeback value.
- instruction  output  32  to alu.instruction.
- regA  output  32  forwarded rs operand, to alu.regA.
- regB  output  32  forwarded rt operand, to alu.regB.
- ex_valid  output  1  EX holds a real instruction.
- ex_dest  output  5  EX destination register; 0 = none.
- ex_is_load  output  1  EX holds lw (opcode 100011).
- stall_req  output  1  combinational; IF/ID must hold this cycle.

Behaviour:
- Registered state:
  - instr_q, rs_q, rt_q, valid_q, dest_q, load_q.
- Reset (rst=1 at clk edge):
  - instr_q=NOP_WORD, rs_q=rt_q=0, valid_q=0, dest_q=0, load_q=0.
  - Hence instruction=0, regA=regB=0, ex_valid=0, ex_dest=0, ex_is_load=0.
  - Reset mid-stall clears everything; stall_req=0 while rst=1.
- Update priority each edge: rst > flush > hold > load-use bubble > capture.
  - flush: load bubble (NOP_WORD, valid 0, dest 0, load 0), even if hold=1.
  - hold: all registers keep their value.
  - Load-use bubble: load bubble; the ID instruction stays in IF/ID via stall_req.
  - Capture: instr_q=id_instr, rs_q=id_rs_data, rt_q=id_rt_data, valid_q=id_valid, plus decoded dest_q and load_q.
- Destination decode:
  - R-type (opcode 0) -> rd.
  - addi/addiu/andi/ori/xori/slti/sltiu/lw -> rt.
  - sw/beq/bne -> 0.
  - dest forced 0 when id_valid=0.
- Source use:
  - rs used except R-type funct sll(000000)/srl(000010)/sra(000011).
  - rt used by R-type, sw, beq, bne.
- Load-use:
  - stall_req = valid_q & load_q & dest_q!=0 & ((rs used & rs==dest_q) | (rt used & rt==dest_q)) & id_valid & !flush & !hold & !rst.
  - One bubble per lw dependency; stall_req drops the following cycle.
- Forwarding (combinational on outputs, per operand):
  - EX/MEM when exmem_wr_en & exmem_wr_addr!=0 & addr==field; else MEM/WB under the same rule; else registered value.
  - EX/MEM wins when both match.
  - Register $0 is never forwarded.
- The register file is write-before-read, so no capture-time bypass.
- Latency: ID values reach the alu one cycle after capture; forwarding adds no cycles.

Optional Feature:
- Macro IDEX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - regA/regB are raw rs_q/rt_q.
  - stall_req additionally asserts for any used source matching a nonzero dest in ID/EX (any instruction, valid_q=1) or in EX/MEM (exmem_wr_en=1).
  - Full interlock; bubbles are inserted until the hazard clears.

Test Plan:
- Reset: rst=1 for 2 cycles with garbage inputs -> instruction=0, regA=regB=0, ex_valid=0, stall_req=0.
- Plain capture: id_instr=0x00010020 (add $0,$0,$1), rs=7, rt=9, no writers -> next cycle instruction=0x00010020, regA=7, regB=9, ex_dest=0.
- EX/MEM priority: captured rs=$3, rt=$4; exmem writes $3=0x11, memwb writes $3=0x22 and $4=0x33 -> regA=0x11, regB=0x33.
- $0 not forwarded:
  - exmem_wr_addr=0, data=0xdead.
  - Expect regA = registered value.
- Load-use: EX holds lw $5 (0x8c050000); ID holds add using $5 -> stall_req=1 for exactly one cycle, next instruction=0 and ex_valid=0, then the add captures.
- Flush vs hold and stall: flush=1 with hold=1 and a pending load-use -> bubble loaded, stall_req=0.
  - With IDEX_FORWARD_EN undefined, back-to-back dependent adds -> two bubble cycles.
